// File: rtl/llr_frame_loader_pkg.sv
// Lmem load-line geometry and loader state encoding.
// Shared by the LLR frame loader and its saturation slice.
package llr_frame_loader_pkg;

  localparam int W         = 6;
  localparam int WIN       = 8;
  localparam int Nb        = 16;
  localparam int Z         = 511;
  localparam int LINEBEATS = 32;
  localparam int LOADLINES = 17;

  localparam int SLOTW = Nb * W;
  localparam int LINEW = LINEBEATS * SLOTW;
  localparam int INW   = Nb * WIN;

  localparam logic [9:0] COL_LAST  = 10'(Z - 1);
  localparam logic [9:0] COL_END   = 10'(LINEBEATS * LOADLINES - 1);
  localparam logic [4:0] BEAT_LAST = 5'(LINEBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/llr_frame_loader_sat.sv
// Symmetric WIN-to-W LLR clip with a clip flag.
// -2^(W-1) is clipped too, so the range stays sign-symmetric.
module llr_sat
  import llr_frame_loader_pkg::*;
(
  input  logic [WIN-1:0] llr_i,
  output logic [W-1:0]   llr_o,
  output logic           clip_o
);

  localparam logic signed [WIN-1:0] HI = WIN'(2 ** (W - 1) - 1);
  localparam logic signed [WIN-1:0] LO = -HI;

  logic signed [WIN-1:0] v;
  assign v = $signed(llr_i);

  always_comb begin
    llr_o  = llr_i[W-1:0];
    clip_o = 1'b0;
    if (v > HI) begin
      llr_o  = HI[W-1:0];
      clip_o = 1'b1;
    end else if (v < LO) begin
      llr_o  = LO[W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Streams channel LLRs into Lmem load lines, zero-padding past Z.
// One beat = one column across all Nb blocks; 32 beats per line.
module llr_frame_loader
  import llr_frame_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [INW-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LINEW-1:0] load_data,
  output logic             loaden,
  output logic             load_done,
  output logic             busy,
  output logic [15:0]      sat_count
);

  state_e           state_q;
  logic [4:0]       beat_q;
  logic [4:0]       line_q;
  logic [9:0]       col_q;
  logic [LINEW-1:0] asm_q;
  logic [LINEW-1:0] asm_d;
  logic [LINEW-1:0] load_q;
  logic [15:0]      sat_q;
  logic [15:0]      sat_d;
  logic             in_ready_q;
  logic             loaden_q;
  logic             load_done_q;
  logic             busy_q;

  logic [SLOTW-1:0] sat_bus;
  logic [SLOTW-1:0] slot_d;
  logic [Nb-1:0]    clip;
  logic [4:0]       pop;
  logic [16:0]      sum;
  logic             acc;
  logic             wr;

  for (genvar n = 0; n < Nb; n++) begin : g_sat
    llr_sat u_sat (
      .llr_i  (in_data[n*WIN +: WIN]),
      .llr_o  (sat_bus[n*W +: W]),
      .clip_o (clip[n])
    );
  end

  assign acc = (state_q == S_FILL) && in_valid && in_ready_q;
  assign wr  = acc || (state_q == S_PAD);

  always_comb begin
    slot_d = acc ? sat_bus : '0;
    asm_d  = asm_q;
    asm_d[int'(beat_q)*SLOTW +: SLOTW] = slot_d;
    pop = '0;
    for (int n = 0; n < Nb; n++) begin
      pop = pop + 5'(clip[n]);
    end
    sum   = {1'b0, sat_q} + 17'(pop);
    sat_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      col_q       <= '0;
      asm_q       <= '0;
      load_q      <= '0;
      sat_q       <= '0;
      in_ready_q  <= 1'b0;
      loaden_q    <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      loaden_q    <= 1'b0;
      load_done_q <= 1'b0;
      if (wr) begin
        asm_q <= asm_d;
        col_q <= col_q + 10'd1;
        if (beat_q == BEAT_LAST) begin
          beat_q   <= '0;
          line_q   <= line_q + 5'd1;
          load_q   <= asm_d;
          loaden_q <= 1'b1;
        end else begin
          beat_q <= beat_q + 5'd1;
        end
      end
      if (acc) sat_q <= sat_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            beat_q     <= '0;
            line_q     <= '0;
            col_q      <= '0;
            sat_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        S_FILL: begin
          if (acc && col_q == COL_LAST) begin
            in_ready_q <= 1'b0;
            state_q    <= (col_q == COL_END) ? S_DONE : S_PAD;
          end
        end
        S_PAD: begin
          if (col_q == COL_END) state_q <= S_DONE;
        end
        S_DONE: begin
          load_done_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign load_data = load_q;
  assign loaden    = loaden_q;
  assign load_done = load_done_q;
  assign busy      = busy_q;
  assign sat_count = sat_q;

endmodule

// File: doc/llr_frame_loader.md
# llr_frame_loader

Upstream feeder for the bit-node LLR memory (Lmem) of the LDPC decoder. Accepts channel LLRs as a valid/ready stream of one column position across all Nb circulant blocks per beat. Saturates each LLR to W bits and packs 32 beats into one Lmem load line. Zero-pads the frame past Z columns, then drives `load_data`/`loaden` for the 17 load lines Lmem expects.

## Interface
- `W`, 6, Lmem LLR width, two's complement
- `WIN`, 8, input LLR width, two's complement
- `Nb`, 16, circulant blocks per layer (LLRs per beat)
- `Z`, 511, circulant size (real columns per frame)
- `LINEBEATS`, 32, beats per load line
- `LOADLINES`, 17, load lines per frame; requires Z ≤ LINEBEATS*LOADLINES
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse, begins a frame
- `in_data`  in  Nb*WIN  one beat; block n at bits [n*WIN +: WIN]
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when in_valid & in_ready
- `load_data`  out  LINEBEATS*Nb*W  packed line to Lmem
- `loaden`  out  1  one-cycle strobe, load_data valid
- `load_done`  out  1  one-cycle pulse, frame fully loaded
- `busy`  out  1  high from start to load_done
- `sat_count`  out  16  LLRs clipped this frame, saturating at 16'hFFFF

## Operation
- States: IDLE, FILL, PAD, DONE.
- IDLE:
  - `start` clears the beat, line and column counters and `sat_count`, then enters FILL.
  - Other inputs are ignored.
- FILL:
  - `in_ready`=1; each accepted beat is written to slot `beat` of the assembly register.
  - Slot k occupies bits [k*Nb*W +: Nb*W]; block n within a slot occupies [n*W +: W].
  - Column index col = line*LINEBEATS + beat; advances only on acceptance.
  - After accepting col = Z-1, go to PAD.
- PAD:
  - `in_ready`=0; one zero slot is written per cycle, with no input consumed.
  - Continues until col = LINEBEATS*LOADLINES-1 (33 pad beats at defaults), then go to DONE.
- Line completion (FILL or PAD):
  - Triggered when beat = LINEBEATS-1 is written.
  - Copy the assembled line, including the slot just written, into the `load_data` register.
  - Increment `line`; beat wraps to 0.
- DONE: `load_done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- Saturation, per LLR:
  - Clip to [-(2^(W-1)-1), +(2^(W-1)-1)], i.e. ±31 at W=6 (6'b011111 / 6'b100001).
  - In-range values are truncated to W bits unchanged.
  - Symmetric: -32 is also clipped.
- `sat_count` increments by the number of LLRs clipped in each accepted beat, 0..Nb per beat, and saturates at 16'hFFFF.
- Reset mid-frame:
  - Returns to IDLE; `load_data`, the assembly register and all outputs are cleared.
  - No further `loaden` is issued; Lmem is reloaded by a fresh frame.

## Timing
- Reset values:
  - `in_ready`=0, `loaden`=0, `load_done`=0, `busy`=0.
  - `load_data`=0, `sat_count`=0.
- `start` at cycle t: `busy`=1 and `in_ready`=1 from t+1.
- Beat completing a line written at cycle t: `loaden`=1 and the new `load_data` visible at t+1.
  - `load_data` holds until the next line's `loaden`.
- Input bubbles delay `loaden`; Lmem advances its load line per `loaden` cycle, so gaps between strobes are legal.
- In PAD, `loaden` strobes are at most LINEBEATS cycles apart.
  - At defaults: line 15 strobes 1 cycle after PAD entry; line 16 strobes 32 cycles later.
- `load_done` fires the cycle after the final (17th) `loaden`; `busy` falls in that same cycle.
- Exactly LOADLINES strobes per frame.
- `in_ready` drops in the cycle after col Z-1 is accepted; a held `in_valid` is not consumed.

## Structure
- Shared decoder package holds W, Nb, Z, LINEBEATS, LOADLINES (the Lmem geometry) and the state enum.
- Sub-module `llr_sat`: combinational WIN→W symmetric clip plus clip flag.
  - Instantiated Nb times; flags popcounted into `sat_count`.
- Counters: beat 5 bits, line 5 bits, col 10 bits.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; `in_ready`=0 until `start`.
- Full frame:
  - Stimulus: LLR (col+n) mod 32, no bubbles.
  - Expect 17 `loaden`; line 0 slot 3 block 2 = 5.
  - Line 15 slot 31 = 0; line 16 all zero.
  - `load_done` one cycle after the 17th `loaden`; `sat_count`=0.
- Saturation:
  - Block values +100, -128, -31, +31, -32 -> 6'b011111, 6'b100001, 6'b100001, 6'b011111, 6'b100001.
  - `sat_count` +3 per beat.
- Bubbles: `in_valid` toggling pseudo-randomly -> same 17 lines bit-exact vs. no-bubble run; `loaden` only on line completion.
- PAD: hold `in_valid`=1 after col 510 -> `in_ready`=0 for 33 cycles; extra beats not consumed.
- `start` pulsed mid-frame -> ignored.
- Reset at line 7 -> no further `loaden`; a subsequent clean frame is bit-exact.
